// File: rtl/hamming_pkg.sv
// Shared Hamming(12,8) definitions: widths, parity bit positions and the serializer state type.
package hamming_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CW_W   = 12;

  // Parity bit positions inside the codeword {p3,p2,p1,p0,d7..d0}.
  localparam int unsigned P0_IDX = 8;
  localparam int unsigned P1_IDX = 9;
  localparam int unsigned P2_IDX = 10;
  localparam int unsigned P3_IDX = 11;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StGap
  } tx_state_e;

endpackage

// File: rtl/hamming_encoder.sv
// Combinational Hamming(12,8) encoder: data bits in [7:0], parity bits p0..p3 in [11:8].
module hamming_encoder
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [CW_W-1:0]   codeword_o
);

  // Parity generation over the fixed data-bit coverage sets.
  always_comb begin
    codeword_o                = '0;
    codeword_o[DATA_W-1:0]    = data_i;
    codeword_o[P0_IDX]        = data_i[0] ^ data_i[1] ^ data_i[3] ^ data_i[4] ^ data_i[6];
    codeword_o[P1_IDX]        = data_i[0] ^ data_i[2] ^ data_i[3] ^ data_i[5] ^ data_i[6];
    codeword_o[P2_IDX]        = data_i[1] ^ data_i[2] ^ data_i[3] ^ data_i[7];
    codeword_o[P3_IDX]        = data_i[4] ^ data_i[5] ^ data_i[6] ^ data_i[7];
  end

endmodule

// File: rtl/hamming_tx_serializer.sv
// Framed serial transmitter: encodes each accepted byte into a 12-bit Hamming codeword and
// shifts it out LSB first between a start bit (0) and a stop bit (1), followed by an idle gap.
// Optional feature macro: HAMMING_TX_ERR_INJECT_EN adds inj_en/inj_pos to flip one codeword bit.
module hamming_tx_serializer
  import hamming_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned FRAME_GAP    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef HAMMING_TX_ERR_INJECT_EN
  input  logic              inj_en,
  input  logic [3:0]        inj_pos,
`endif
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              tx_line,
  output logic              busy,
  output logic [15:0]       frames_sent
);

  localparam logic [7:0] CntLast  = 8'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DataLast = 4'(CW_W - 1);
  localparam logic [3:0] GapLast  = (FRAME_GAP == 0) ? 4'd0 : 4'(FRAME_GAP - 1);

  tx_state_e         state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [3:0]        bit_q, bit_d;
  logic [CW_W-1:0]   shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic [15:0]       frames_q, frames_d;
  logic              rdy_en_q;
  logic [CW_W-1:0]   cw, cw_tx;
  logic              bit_end;

  hamming_encoder u_enc (
    .data_i     (s_data),
    .codeword_o (cw)
  );

`ifdef HAMMING_TX_ERR_INJECT_EN
  // Flip the selected codeword bit; positions beyond the codeword are ignored.
  always_comb begin
    cw_tx = cw;
    if (inj_en && (inj_pos <= DataLast)) begin
      cw_tx = cw ^ (12'b1 << inj_pos);
    end
  end
`else
  assign cw_tx = cw;
`endif

  // rdy_en_q keeps s_ready low while reset is asserted and through the first edge after it.
  assign s_ready     = (state_q == StIdle) && rdy_en_q;
  assign busy        = (state_q != StIdle);
  assign tx_line     = tx_q;
  assign frames_sent = frames_q;
  assign bit_end     = (cnt_q == CntLast);

  // Next-state logic: bit-period counting, shifting and frame sequencing.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    frames_d = frames_q;

    unique case (state_q)
      StIdle: begin
        if (s_valid && s_ready) begin
          shreg_d = cw_tx;
          bit_d   = '0;
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d   = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == DataLast) begin
            bit_d   = '0;
            state_d = StStop;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d    = '0;
          bit_d    = '0;
          frames_d = frames_q + 16'd1;
          state_d  = (FRAME_GAP == 0) ? StIdle : StGap;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StGap: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == GapLast) begin
            bit_d   = '0;
            state_d = StIdle;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level for the next cycle, derived from the next state so tx_line can be registered.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State registers with synchronous active-low reset; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      frames_q <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      frames_q <= frames_d;
      rdy_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Directed bench for hamming_tx_serializer: one instance with CLKS_PER_BIT=1 and one with 4.
module tb_hamming_tx_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1_n, rst4_n;
  logic        s_valid;
  logic [7:0]  s_data;
`ifdef HAMMING_TX_ERR_INJECT_EN
  logic        inj_en;
  logic [3:0]  inj_pos;
`endif

  logic        tx1, rdy1, busy1;
  logic [15:0] fr1;
  logic        tx4, rdy4, busy4;
  logic [15:0] fr4;

  // Selects which instance the frame task observes.
  logic        sel4;
  logic        tx_m, rdy_m, busy_m;
  logic [15:0] fr_m;
  assign tx_m   = sel4 ? tx4 : tx1;
  assign rdy_m  = sel4 ? rdy4 : rdy1;
  assign busy_m = sel4 ? busy4 : busy1;
  assign fr_m   = sel4 ? fr4 : fr1;

  hamming_tx_serializer #(
    .CLKS_PER_BIT (1),
    .FRAME_GAP    (1)
  ) u_dut1 (
    .clk         (clk),
    .rst_n       (rst1_n),
`ifdef HAMMING_TX_ERR_INJECT_EN
    .inj_en      (inj_en),
    .inj_pos     (inj_pos),
`endif
    .s_valid     (s_valid),
    .s_ready     (rdy1),
    .s_data      (s_data),
    .tx_line     (tx1),
    .busy        (busy1),
    .frames_sent (fr1)
  );

  hamming_tx_serializer #(
    .CLKS_PER_BIT (4),
    .FRAME_GAP    (1)
  ) u_dut4 (
    .clk         (clk),
    .rst_n       (rst4_n),
`ifdef HAMMING_TX_ERR_INJECT_EN
    .inj_en      (inj_en),
    .inj_pos     (inj_pos),
`endif
    .s_valid     (s_valid),
    .s_ready     (rdy4),
    .s_data      (s_data),
    .tx_line     (tx4),
    .busy        (busy4),
    .frames_sent (fr4)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake one byte in the current (IDLE) cycle and check the full frame, gap and return to IDLE.
  task automatic send_frame(input logic [7:0] d, input logic [11:0] cw, input int c,
                            input bit hold, input logic [15:0] exp_fr);
    logic [13:0] fb;
    fb = {1'b1, cw, 1'b0};
    s_data  = d;
    s_valid = 1'b1;
    check_eq("ready_idle", 32'(rdy_m), 32'd1);
    tick();
    if (!hold) s_valid = 1'b0;
    for (int b = 0; b < 14; b++) begin
      for (int k = 0; k < c; k++) begin
        check_eq($sformatf("d%02h_bit%0d_c%0d", d, b, k), 32'(tx_m), 32'(fb[b]));
        if (b == 0 && k == 0) begin
          check_eq("busy_start", 32'(busy_m), 32'd1);
          check_eq("ready_start", 32'(rdy_m), 32'd0);
        end
        if (b == 13 && k == c - 1) check_eq("frames_in_stop", 32'(fr_m), 32'(exp_fr - 16'd1));
        tick();
      end
    end
    for (int k = 0; k < c; k++) begin
      check_eq($sformatf("gap_c%0d", k), 32'(tx_m), 32'd1);
      if (k == 0) check_eq("frames_after_stop", 32'(fr_m), 32'(exp_fr));
      tick();
    end
    check_eq("ready_back", 32'(rdy_m), 32'd1);
    check_eq("busy_back", 32'(busy_m), 32'd0);
  endtask

  initial begin
    sel4    = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    rst1_n  = 1'b0;
    rst4_n  = 1'b0;
`ifdef HAMMING_TX_ERR_INJECT_EN
    inj_en  = 1'b0;
    inj_pos = 4'd0;
`endif

    // Reset: three cycles held low.
    repeat (3) tick();
    check_eq("rst_tx", 32'(tx1), 32'd1);
    check_eq("rst_ready", 32'(rdy1), 32'd0);
    check_eq("rst_busy", 32'(busy1), 32'd0);
    check_eq("rst_frames", 32'(fr1), 32'd0);
    check_eq("rst_tx4", 32'(tx4), 32'd1);
    rst1_n = 1'b1;
    tick();
    check_eq("ready_after_rst", 32'(rdy1), 32'd1);

    // Single frame 0xAA -> 0x4AA.
    send_frame(8'hAA, 12'h4AA, 1, 1'b0, 16'd1);

    // Back-to-back 0x01 then 0xFF with valid held, from a fresh reset.
    rst1_n = 1'b0;
    tick();
    rst1_n = 1'b1;
    tick();
    send_frame(8'h01, 12'h301, 1, 1'b1, 16'd1);
    send_frame(8'hFF, 12'h3FF, 1, 1'b0, 16'd2);

    // Mid-frame reset during data bit 5 of 0x301 (bit value 0).
    s_data  = 8'h01;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    repeat (6) tick();
    check_eq("pre_rst_bit5", 32'(tx1), 32'd0);
    check_eq("pre_rst_busy", 32'(busy1), 32'd1);
    rst1_n = 1'b0;
    tick();
    check_eq("midrst_tx", 32'(tx1), 32'd1);
    check_eq("midrst_busy", 32'(busy1), 32'd0);
    check_eq("midrst_ready", 32'(rdy1), 32'd0);
    check_eq("midrst_frames", 32'(fr1), 32'd0);
    rst1_n = 1'b1;
    tick();
    check_eq("midrst_ready_rel", 32'(rdy1), 32'd1);
    send_frame(8'hAA, 12'h4AA, 1, 1'b0, 16'd1);

`ifdef HAMMING_TX_ERR_INJECT_EN
    // Injection: bit 11 flipped, then an out-of-range position leaves the codeword intact.
    inj_en  = 1'b1;
    inj_pos = 4'd11;
    send_frame(8'hAA, 12'hCAA, 1, 1'b0, 16'd2);
    inj_pos = 4'd13;
    send_frame(8'hAA, 12'h4AA, 1, 1'b0, 16'd3);
    inj_en  = 1'b0;
`endif

    // Divider: CLKS_PER_BIT=4, each bit held exactly 4 cycles.
    rst1_n = 1'b0;
    sel4   = 1'b1;
    rst4_n = 1'b1;
    tick();
    send_frame(8'h01, 12'h301, 4, 1'b0, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
